// File: rtl/shift_scan_pkg.sv
// Shared types and constants for the shift/scan sequencer and its "01" pattern detector.
package shift_scan_pkg;

  localparam int unsigned DEFAULT_WIDTH     = 10;
  localparam int unsigned MATCH_COUNT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } scan_state_t;

  typedef enum logic [1:0] {
    DET_S0,
    DET_S1,
    DET_S2
  } det_state_t;

endpackage

// File: rtl/shift_scan_if.sv
// Control/status bundle between the tick/start logic, the scan sequencer and the display logic.
interface shift_scan_if
  import shift_scan_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic                         tick;
  logic                         start;
  logic                         abort;
  logic [WIDTH-1:0]             pattern;
  logic [WIDTH-1:0]             shift_data;
  logic                         serial_out;
  logic                         step;
  logic                         detect;
  logic [MATCH_COUNT_WIDTH-1:0] match_count;
  logic                         busy;
  logic                         done;

  modport master (
    output tick, start, abort, pattern,
    input  shift_data, serial_out, step, detect, match_count, busy, done
  );

  modport slave (
    input  tick, start, abort, pattern,
    output shift_data, serial_out, step, detect, match_count, busy, done
  );

endinterface

// File: rtl/pattern_detect_step.sv
// Moore "01" detector (Smiling Snail) advanced only on enable; y marks S2, hit flags the S1->S2 step.
module pattern_detect_step
  import shift_scan_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  input  logic a,
  output logic y,
  output logic hit
);

  det_state_t state, state_next;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= DET_S0;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = DET_S0;
    end else if (enable) begin
      unique case (state)
        DET_S0:  state_next = a ? DET_S0 : DET_S1;
        DET_S1:  state_next = a ? DET_S2 : DET_S1;
        DET_S2:  state_next = a ? DET_S0 : DET_S1;
        default: state_next = DET_S0;
      endcase
    end
  end

  assign y   = (state == DET_S2);
  assign hit = enable & a & (state == DET_S1);

endmodule

// File: rtl/shift_scan_controller.sv
// Captures a pattern on start and shifts it out LSB-first on tick, counting "01" hits.
// Optional macro SCAN_LOOP_EN: DONE re-captures the pattern and restarts the scan.
module shift_scan_controller
  import shift_scan_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input logic         clock,
  input logic         reset,
  shift_scan_if.slave bus
);

  localparam int unsigned     CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  scan_state_t                  state, state_next;
  logic [WIDTH-1:0]             shift_data;
  logic [CNT_W-1:0]             bit_cnt;
  logic [MATCH_COUNT_WIDTH-1:0] match_count;
  logic                         step;
  logic                         load;
  logic                         hit;
  logic                         detect;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // abort masks the tick so nothing shifts or counts in that cycle
        step = bus.tick & ~bus.abort;
        if (bus.abort) begin
          state_next = ST_IDLE;
        end else if (step && (bit_cnt == LAST_BIT)) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
`ifdef SCAN_LOOP_EN
        load       = 1'b1;
        state_next = ST_SHIFT;
`else
        state_next = ST_IDLE;
`endif
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_data  <= '0;
      bit_cnt     <= '0;
      match_count <= '0;
    end else if (load) begin
      shift_data  <= bus.pattern;
      bit_cnt     <= '0;
      match_count <= '0;
    end else if (step) begin
      shift_data <= {1'b0, shift_data[WIDTH-1:1]};
      bit_cnt    <= bit_cnt + CNT_W'(1);
      if (hit) begin
        match_count <= match_count + MATCH_COUNT_WIDTH'(1);
      end
    end
  end

  pattern_detect_step u_detect (
    .clock  (clock),
    .reset  (reset),
    .enable (step),
    .clear  (load),
    .a      (shift_data[0]),
    .y      (detect),
    .hit    (hit)
  );

  assign bus.shift_data  = shift_data;
  assign bus.serial_out  = shift_data[0];
  assign bus.step        = step;
  assign bus.detect      = detect;
  assign bus.match_count = match_count;
  assign bus.busy        = (state == ST_SHIFT);
  assign bus.done        = (state == ST_DONE);

endmodule
